// File: rtl/alu_iter.sv
// Multi-cycle RV32I ALU: single-cycle arith/logic ops, an iterative shifter and an optional radix-2 multiplier.
// The multiplier is built only when ALU_ITER_MUL_EN is defined.
module alu_iter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [XLEN-1:0] arg1_i,
  input  logic [XLEN-1:0] arg2_i,
  input  logic [2:0]      funct3_i,
  input  logic            sub_sra_i,
  input  logic            mul_i,
  output logic [XLEN-1:0] res_o,
  output logic            done_o,
  output logic            busy_o
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            left_q, left_d;
  logic            sra_q, sra_d;

  logic            mul_eff;
  logic            is_shift;
  logic [XLEN-1:0] alu_res;

`ifdef ALU_ITER_MUL_EN
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic              neg_q, neg_d;
  logic              hi_q, hi_d;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     psum;
  logic [2*XLEN-1:0] acc_step, prod;

  assign mul_eff = mul_i;
  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
  assign a_neg = (funct3_i[1] ^ funct3_i[0]) & arg1_i[XLEN-1];
  assign b_neg = (funct3_i[1:0] == 2'b01) & arg2_i[XLEN-1];
  assign a_mag = a_neg ? -arg1_i : arg1_i;
  assign b_mag = b_neg ? -arg2_i : arg2_i;
  assign psum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step = {psum, acc_q[XLEN-1:1]};
  assign prod     = neg_q ? -acc_step : acc_step;
`else
  logic unused_mul;
  assign mul_eff    = 1'b0;
  assign unused_mul = mul_i;
`endif

  assign is_shift = ~mul_eff & (funct3_i[1:0] == 2'b01);
  assign busy_o   = (state_q != IDLE);

  always_comb begin
    alu_res = '0;
    case (funct3_i)
      3'b000: alu_res = sub_sra_i ? arg1_i - arg2_i : arg1_i + arg2_i;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(arg1_i) < $signed(arg2_i)};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, arg1_i < arg2_i};
      3'b100: alu_res = arg1_i ^ arg2_i;
      3'b110: alu_res = arg1_i | arg2_i;
      3'b111: alu_res = arg1_i & arg2_i;
      default: alu_res = '0;
    endcase
    // Divide ops under the M extension are answered with zero in one cycle.
    if (mul_eff) alu_res = '0;
  end

  // Shift by at most SHIFT_STEP per cycle; the final step may be shorter.
  logic [CW-1:0]     amt;
  logic              fill;
  logic [2*XLEN-1:0] sh_r_wide;
  logic [XLEN-1:0]   sh_val;

  assign amt       = (cnt_q < STEP) ? cnt_q : STEP;
  assign fill      = sra_q & res_q[XLEN-1];
  assign sh_r_wide = {{XLEN{fill}}, res_q} >> amt;
  assign sh_val    = left_q ? (res_q << amt) : sh_r_wide[XLEN-1:0];

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    sra_d   = sra_q;
    res_o   = res_q;
    done_o  = 1'b0;
`ifdef ALU_ITER_MUL_EN
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef ALU_ITER_MUL_EN
          if (mul_i && !funct3_i[2]) begin
            state_d = MUL;
            cnt_d   = CW'(XLEN);
            acc_d   = {{XLEN{1'b0}}, b_mag};
            mcand_d = a_mag;
            neg_d   = a_neg ^ b_neg;
            hi_d    = (funct3_i[1:0] != 2'b00);
          end else
`endif
          if (is_shift) begin
            res_d   = arg1_i;
            left_d  = ~funct3_i[2];
            sra_d   = funct3_i[2] & (sub_sra_i | arg2_i[10]);
            cnt_d   = {1'b0, arg2_i[SW-1:0]};
            state_d = (arg2_i[SW-1:0] == '0) ? DONE : SHIFT;
          end else begin
            res_o  = alu_res;
            done_o = 1'b1;
          end
        end
      end
      SHIFT: begin
        res_d = sh_val;
        cnt_d = cnt_q - amt;
        if (cnt_q == amt) state_d = DONE;
      end
`ifdef ALU_ITER_MUL_EN
      MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          res_d   = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      sra_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      sra_q   <= sra_d;
    end
  end

`ifdef ALU_ITER_MUL_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
    end
  end
`endif
endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: one instance with SHIFT_STEP=1, one with SHIFT_STEP=4.
module tb_alu_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  f3 = '0;
  logic        sub = 1'b0, mul = 1'b0;
  logic [31:0] res1, res4;
  logic        done1, done4, busy1, busy4;

  int checks = 0;
  int errors = 0;
  logic [31:0] q_res[$];
  int          q_lat[$];

  always #5 clk = ~clk;

  alu_iter #(.XLEN(32), .SHIFT_STEP(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .arg1_i(a), .arg2_i(b),
    .funct3_i(f3), .sub_sra_i(sub), .mul_i(mul),
    .res_o(res1), .done_o(done1), .busy_o(busy1));

  alu_iter #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .arg1_i(a), .arg2_i(b),
    .funct3_i(f3), .sub_sra_i(sub), .mul_i(mul),
    .res_o(res4), .done_o(done4), .busy_o(busy4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] fn, input logic sb,
                                           input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (fn)
      3'b000: r = sb ? x - y : x + y;
      3'b001: r = x << y[4:0];
      3'b010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011: r = (x < y) ? 32'd1 : 32'd0;
      3'b100: r = x ^ y;
      3'b101: r = (sb | y[10]) ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'b110: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] fn, input logic [31:0] y, input int step);
    if (fn[1:0] != 2'b01) return 0;
    return (int'(y[4:0]) + step - 1) / step + 1;
  endfunction

  // Drive one request; the expected result/latency goes through the scoreboard queue.
  task automatic issue(input string tag, input bit s4, input logic [2:0] fn, input bit sb,
                       input bit ml, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input int el, input bit perturb);
    logic [31:0] r, pr;
    int lat, pl;
    bit got;
    q_res.push_back(er);
    q_lat.push_back(el);
    @(negedge clk);
    f3 = fn; sub = sb; mul = ml; a = x; b = y;
    if (s4) start4 = 1'b1; else start1 = 1'b1;
    #1;
    got = 1'b0; lat = 0; r = '0;
    if (s4 ? done4 : done1) begin
      got = 1'b1;
      r = s4 ? res4 : res1;
      chk({tag, "_busy_sc"}, 64'(s4 ? busy4 : busy1), 64'd0);
      @(posedge clk); #1;
    end
    for (int n = 1; n <= 80 && !got; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin start1 = 1'b0; start4 = 1'b0; end
      if (perturb && n == 2) begin
        if (s4) start4 = 1'b1; else start1 = 1'b1;
        f3 = 3'b000; a = ~x;
      end
      @(negedge clk);
      if (perturb && n == 3) chk({tag, "_busy"}, 64'(s4 ? busy4 : busy1), 64'd1);
      if (s4 ? done4 : done1) begin got = 1'b1; lat = n; r = s4 ? res4 : res1; end
    end
    start1 = 1'b0; start4 = 1'b0;
    pr = q_res.pop_front();
    pl = q_lat.pop_front();
    if (!got) chk({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      chk({tag, "_res"}, 64'(r), 64'(pr));
      chk({tag, "_lat"}, 64'(lat), 64'(pl));
    end
    @(negedge clk);
    chk({tag, "_one_pulse"}, 64'(s4 ? done4 : done1), 64'd0);
    chk({tag, "_idle"}, 64'(s4 ? busy4 : busy1), 64'd0);
  endtask

  initial begin
    logic [2:0] sc_ops [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
    logic [31:0] x, y;
    logic [2:0] fn;
    logic sb;

    #1;
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_res1",  64'(res1),  64'd0);
    chk("rst_res4",  64'(res4),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("add_wrap", 0, 3'b000, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0);
    issue("sub_wrap", 0, 3'b000, 1, 0, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 0);
    issue("slt",      0, 3'b010, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0);
    issue("sltu",     0, 3'b011, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      x = $urandom; y = $urandom; fn = sc_ops[i]; sb = 1'($urandom_range(0, 1));
      issue("rand_sc", 0, fn, sb, 0, x, y, ref_alu(fn, sb, x, y), 0, 0);
    end

    issue("sra31",    0, 3'b101, 1, 0, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 0);
    issue("sra_b10",  0, 3'b101, 0, 0, 32'h8000_0000, 32'h41F, 32'hFFFF_FFFF, 32, 0);
    issue("srl31",    0, 3'b101, 0, 0, 32'h8000_0000, 32'd31, 32'h1, 32, 0);
    chk("hold_res", 64'(res1), 64'h1);
    issue("add_nowr", 0, 3'b000, 0, 0, 32'd2, 32'd3, 32'd5, 0, 0);
    chk("hold_after_sc", 64'(res1), 64'h1);

    issue("s4_sll7",  1, 3'b001, 0, 0, 32'h1, 32'd7, 32'h80, 3, 0);
    issue("s4_sh0",   1, 3'b101, 1, 0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1, 0);
    for (int i = 0; i < 6; i++) begin
      x = $urandom; y = $urandom; fn = i[0] ? 3'b101 : 3'b001; sb = 1'($urandom_range(0, 1));
      issue("s4_rand", 1, fn, sb, 0, x, y, ref_alu(fn, sb, x, y), ref_lat(fn, y, 4), 0);
      x = $urandom; y = $urandom;
      issue("s1_rand", 0, fn, sb, 0, x, y, ref_alu(fn, sb, x, y), ref_lat(fn, y, 1), 0);
    end

    issue("guard", 0, 3'b001, 0, 0, 32'h0000_0003, 32'd10, 32'h0000_0C00, 11, 1);

    // Reset in the middle of a 20-cycle shift.
    @(negedge clk);
    f3 = 3'b001; sub = 0; mul = 0; a = 32'h1; b = 32'd19; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 64'(busy1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy1), 64'd0);
    chk("rst_mid_done", 64'(done1), 64'd0);
    chk("rst_mid_res",  64'(res1),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue("add_after_rst", 0, 3'b000, 0, 0, 32'd40, 32'd2, 32'd42, 0, 0);
    chk("res_after_rst", 64'(res1), 64'd0);

`ifdef ALU_ITER_MUL_EN
    issue("mulh",  0, 3'b001, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, 0);
    issue("mulhu", 0, 3'b011, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    issue("mul",   0, 3'b000, 0, 1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    issue("mulhsu",0, 3'b010, 0, 1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0);
    issue("div0",  0, 3'b100, 0, 1, 32'd9, 32'd3, 32'h0, 0, 0);
`else
    issue("mul_ign", 0, 3'b000, 0, 1, 32'd7, 32'd3, 32'd10, 0, 0);
    issue("mul_ign_sh", 1, 3'b001, 0, 1, 32'h1, 32'd4, 32'h10, 2, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
